serial_tx: RTL

SERIAL_TX -- requirements
Module: serial_tx

---
 rtl/serial_pkg.sv | 17 +
 rtl/serial_tx_bit_timer.sv | 40 ++++
 rtl/serial_tx.sv | 107 ++++++++++
 3 files changed

// File: rtl/serial_pkg.sv
// serial_pkg
// Shared definitions for the serial transmitter slice: the frame state
// encoding and the default payload width / bit period used by serial_tx.
package serial_pkg;

  // Frame phases: idle line, start bit, payload bits, stop bit.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } serial_state_t;

  localparam int DEF_DATA_W  = 8;
  localparam int DEF_BIT_CYC = 4;

endpackage : serial_pkg

// File: rtl/serial_tx_bit_timer.sv
// bit_timer
// Modulo-BIT_CYC cycle counter that marks the last cycle of each serial bit.
// Ports:
//   clk    - clock, rising edge
//   rst    - synchronous active-high reset, clears the count
//   clear  - synchronous clear, restarts the bit period from zero
//   enable - count this cycle
//   wrap   - high in the last cycle of a bit period (count == BIT_CYC-1)
module bit_timer #(
  parameter int BIT_CYC = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic wrap
);

  localparam int CW = $clog2(BIT_CYC) + 1;
  localparam logic [CW-1:0] LAST = CW'(BIT_CYC - 1);
  localparam logic [CW-1:0] ONE  = CW'(1);

  logic [CW-1:0] count;

  // With BIT_CYC=1 the count never leaves zero, so every enabled cycle wraps.
  assign wrap = enable && (count == LAST);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
    end else if (enable) begin
      if (count == LAST) begin
        count <= '0;
      end else begin
        count <= count + ONE;
      end
    end
  end

endmodule : bit_timer

// File: rtl/serial_tx.sv
// serial_tx
// Parallel-to-serial transmitter. An accepted word is sent as a frame of a
// start bit (0), DATA_W payload bits LSB first and a stop bit (1), each bit
// held for BIT_CYC clock cycles. The line idles at 1.
// Ports:
//   clk      - clock, rising edge
//   rst      - synchronous active-high reset, aborts any frame
//   tx_data  - word to send, captured on accept
//   tx_valid - producer offers tx_data
//   tx_ready - block can accept a word this cycle (IDLE and not in reset)
//   sdo      - registered serial line
//   busy     - a frame is in progress
//   done     - one-cycle pulse in the first IDLE cycle after the stop bit
module serial_tx
  import serial_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int BIT_CYC = DEF_BIT_CYC
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic              sdo,
  output logic              busy,
  output logic              done
);

  localparam int BW = $clog2(DATA_W) + 1;
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_W - 1);
  localparam logic [BW-1:0] BIT_ONE  = BW'(1);

  serial_state_t     state;
  logic [DATA_W-1:0] shift_reg;
  logic [BW-1:0]     bit_cnt;
  logic              accept;
  logic              bit_wrap;

  assign tx_ready = (state == IDLE) && !rst;
  assign busy     = (state != IDLE) && !rst;
  assign accept   = tx_valid && tx_ready;

  // Restarting the timer on accept aligns the first bit period with the
  // cycle right after the accept edge.
  bit_timer #(
    .BIT_CYC (BIT_CYC)
  ) u_bit_timer (
    .clk    (clk),
    .rst    (rst),
    .clear  (accept),
    .enable (state != IDLE),
    .wrap   (bit_wrap)
  );

  // Frame sequencer. sdo is loaded with the next bit on each bit-period
  // wrap, so the line changes exactly at bit boundaries.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      sdo       <= 1'b1;
      done      <= 1'b0;
      shift_reg <= '0;
      bit_cnt   <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            shift_reg <= tx_data;
            bit_cnt   <= '0;
            sdo       <= 1'b0;
            state     <= START;
          end
        end
        START: begin
          if (bit_wrap) begin
            sdo       <= shift_reg[0];
            shift_reg <= shift_reg >> 1;
            state     <= DATA;
          end
        end
        DATA: begin
          if (bit_wrap) begin
            if (bit_cnt == LAST_BIT) begin
              sdo     <= 1'b1;
              bit_cnt <= '0;
              state   <= STOP;
            end else begin
              sdo       <= shift_reg[0];
              shift_reg <= shift_reg >> 1;
              bit_cnt   <= bit_cnt + BIT_ONE;
            end
          end
        end
        STOP: begin
          if (bit_wrap) begin
            done  <= 1'b1;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule : serial_tx
